// File: rtl/net_pkg.sv
// Shared constants for the frame link: codes, lengths, field positions, FSM encoding.
// Latency: n/a (declarations only); backpressure: n/a.
package net_pkg;

    localparam int         ID_W         = 2;
    localparam int         FRAME_W      = 128;
    localparam logic [7:0] ACK_CODE_DEF = 8'hA5;
    localparam logic [7:0] NAK_CODE_DEF = 8'h5A;
    localparam logic [3:0] RESP_LEN     = 4'd3;

    localparam int CODE_LSB = 0;
    localparam int SEQ_LSB  = 8;
    localparam int ID_LSB   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GAP     = 3'd1;
    localparam logic [2:0] ST_WAIT_TX = 3'd2;
    localparam logic [2:0] ST_START   = 3'd3;
    localparam logic [2:0] ST_CONFIRM = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    typedef struct packed {
        logic            nak;
        logic [ID_W-1:0] id;
        logic [7:0]      seq;
    } evt_t;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0]      code,
                                                       input logic [7:0]      seq,
                                                       input logic [ID_W-1:0] id);
        logic [FRAME_W-1:0] f;
        f                   = '0;
        f[CODE_LSB +: 8]    = code;
        f[SEQ_LSB +: 8]     = seq;
        f[ID_LSB +: ID_W]   = id;
        return f;
    endfunction

endpackage

// File: rtl/ack_responder_if.sv
// Receiver-event inputs and transmitter request/response signals of the responder.
// Latency: n/a (wiring only); backpressure: tx_busy level from the transmitter.
interface ack_responder_if;
    import net_pkg::*;

    logic               rx_valid;
    logic               rx_crc_err;
    logic [FRAME_W-1:0] rx_data;
    logic [3:0]         rx_len;
    logic [ID_W-1:0]    sender_id;
    logic               tx_busy;
    logic               tx_start;
    logic [FRAME_W-1:0] tx_data;
    logic [3:0]         tx_len;
    logic [ID_W-1:0]    tx_dest_id;

    modport slave (
        input  rx_valid, rx_crc_err, rx_data, rx_len, sender_id, tx_busy,
        output tx_start, tx_data, tx_len, tx_dest_id
    );

    modport master (
        output rx_valid, rx_crc_err, rx_data, rx_len, sender_id, tx_busy,
        input  tx_start, tx_data, tx_len, tx_dest_id
    );
endinterface

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
// Latency: 1 cycle from inc_i to cnt_o; backpressure: none.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/ack_responder.sv
// Answers each received frame with an ACK (good) or NAK (CRC error) after a turnaround gap.
// Latency: tx_start 502 cycles after the rx edge when idle; backpressure: waits on tx_busy.
module ack_responder
    import net_pkg::*;
#(
    parameter int         TURNAROUND_CYC  = 500,
    parameter int         CONFIRM_TIMEOUT = 1000,
    parameter bit         NAK_ENABLE      = 1'b1,
    parameter logic [7:0] ACK_CODE        = ACK_CODE_DEF,
    parameter logic [7:0] NAK_CODE        = NAK_CODE_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [ID_W-1:0] my_id,
    ack_responder_if.slave  bus,
    output logic            resp_busy,
    output logic            dup_flag,
    output logic [7:0]      ack_cnt,
    output logic [7:0]      nak_cnt,
    output logic [7:0]      drop_cnt,
    output logic            tx_timeout_err
);
    localparam int MAX_CYC = (TURNAROUND_CYC > CONFIRM_TIMEOUT) ? TURNAROUND_CYC : CONFIRM_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, rxv_q, crc_q;
    logic             slot_vld_q;
    evt_t             slot_q, act_q, ev_new;
    logic [3:0]       tbl_vld_q;
    logic [7:0]       tbl_seq_q [4];
    logic             dup_q, to_err_q;
    logic             rise_v, rise_e, ev_hit, take, hold;
    logic             ack_inc, nak_inc, drop_inc, to_set, load_act;
    logic             unused_rx;

    // armed_q masks the first cycle after reset so a level already high is not an edge
    assign rise_v   = armed_q & bus.rx_valid & ~rxv_q;
    assign rise_e   = armed_q & bus.rx_crc_err & ~crc_q;
    assign ev_hit   = (rise_v | rise_e) & enable & (bus.sender_id != my_id)
                      & (rise_e | (bus.rx_len != 4'd0));
    assign ev_new   = {rise_e, bus.sender_id, bus.rx_data[7:0]};
    assign take     = (state_q == ST_IDLE) & slot_vld_q;
    assign drop_inc = ev_hit & slot_vld_q & ~take;
    assign unused_rx = ^bus.rx_data[FRAME_W-1:8];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_inc  = 1'b0;
        nak_inc  = 1'b0;
        to_set   = 1'b0;
        load_act = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_vld_q) begin
                    if (slot_q.nak && !NAK_ENABLE) begin
                        nak_inc = 1'b1;
                    end else begin
                        load_act = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(TURNAROUND_CYC - 1)) state_d = ST_WAIT_TX;
                else                                     cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_TX: begin
                if (!bus.tx_busy) state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (bus.tx_busy) begin
                    ack_inc = ~act_q.nak;
                    nak_inc = act_q.nak;
                    state_d = ST_DRAIN;
                end else if (cnt_q == CNT_W'(CONFIRM_TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus.tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            rxv_q      <= 1'b0;
            crc_q      <= 1'b0;
            slot_vld_q <= 1'b0;
            slot_q     <= '0;
            act_q      <= '0;
            tbl_vld_q  <= '0;
            dup_q      <= 1'b0;
            to_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) tbl_seq_q[i] <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            rxv_q   <= bus.rx_valid;
            crc_q   <= bus.rx_crc_err;
            if (ev_hit) begin
                slot_vld_q <= 1'b1;
                slot_q     <= ev_new;
            end else if (take) begin
                slot_vld_q <= 1'b0;
            end
            if (load_act) begin
                act_q <= slot_q;
                if (!slot_q.nak) begin
                    dup_q                 <= tbl_vld_q[slot_q.id] && (tbl_seq_q[slot_q.id] == slot_q.seq);
                    tbl_vld_q[slot_q.id]  <= 1'b1;
                    tbl_seq_q[slot_q.id]  <= slot_q.seq;
                end
            end
            if (to_set) to_err_q <= 1'b1;
        end
    end

    assign hold           = (state_q == ST_START) || (state_q == ST_CONFIRM) || (state_q == ST_DRAIN);
    assign bus.tx_start   = (state_q == ST_START);
    assign bus.tx_data    = hold ? build_frame(act_q.nak ? NAK_CODE : ACK_CODE,
                                               act_q.nak ? 8'h00 : act_q.seq, my_id) : '0;
    assign bus.tx_len     = hold ? RESP_LEN : 4'd0;
    assign bus.tx_dest_id = hold ? act_q.id : '0;
    assign resp_busy      = (state_q != ST_IDLE);
    assign dup_flag       = dup_q;
    assign tx_timeout_err = to_err_q;

    sat_counter8 u_ack  (.clk(clk), .rst_n(rst_n), .inc_i(ack_inc),  .cnt_o(ack_cnt));
    sat_counter8 u_nak  (.clk(clk), .rst_n(rst_n), .inc_i(nak_inc),  .cnt_o(nak_cnt));
    sat_counter8 u_drop (.clk(clk), .rst_n(rst_n), .inc_i(drop_inc), .cnt_o(drop_cnt));
endmodule

// File: tb/tb_ack_responder.sv
// Directed vector table plus hand sequences for overwrite, timeout, reset and NAK-disable.
module tb_ack_responder;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic       auto_busy;
    logic       resp_busy, dup_flag, tx_timeout_err;
    logic [7:0] ack_cnt, nak_cnt, drop_cnt;
    logic       resp_busy2, dup_flag2, tx_timeout_err2;
    logic [7:0] ack_cnt2, nak_cnt2, drop_cnt2;
    int         n_chk, n_pass, n_start, n_start2;
    logic [19:0] txq[$];

    ack_responder_if bus ();
    ack_responder_if bus2 ();

    ack_responder dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .my_id(2'd1), .bus(bus),
        .resp_busy(resp_busy), .dup_flag(dup_flag), .ack_cnt(ack_cnt), .nak_cnt(nak_cnt),
        .drop_cnt(drop_cnt), .tx_timeout_err(tx_timeout_err)
    );

    ack_responder #(.NAK_ENABLE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en), .my_id(2'd1), .bus(bus2),
        .resp_busy(resp_busy2), .dup_flag(dup_flag2), .ack_cnt(ack_cnt2), .nak_cnt(nak_cnt2),
        .drop_cnt(drop_cnt2), .tx_timeout_err(tx_timeout_err2)
    );

    typedef struct {
        logic        v, e, en;
        logic [1:0]  sid;
        logic [7:0]  seq;
        logic [3:0]  len;
        logic        resp;
        logic [17:0] exp_f;
        logic [1:0]  exp_dest;
        logic        exp_dup;
        logic [7:0]  exp_ack, exp_nak;
    } vec_t;

    vec_t tv [10];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_start) begin
            n_start++;
            txq.push_back({bus.tx_dest_id, bus.tx_data[17:0]});
        end
        if (bus2.tx_start) n_start2++;
    end

    // Transmitter model: goes busy 2 cycles after a request, for 2 cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_busy && bus.tx_start) begin
                repeat (2) @(negedge clk);
                bus.tx_busy = 1'b1;
                repeat (2) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic pulse(input logic [1:0] sid, input logic [7:0] seq);
        @(negedge clk);
        bus.sender_id = sid;
        bus.rx_data   = {120'h0, seq};
        bus.rx_len    = 4'd4;
        bus.rx_valid  = 1'b1;
        @(negedge clk);
        bus.rx_valid  = 1'b0;
    endtask

    task automatic run_row(input int idx, input vec_t t);
        int           lat;
        logic [127:0] f;
        logic [3:0]   l;
        logic [1:0]   d;
        lat = -1; f = '0; l = '0; d = '0;
        @(negedge clk);
        en             = t.en;
        bus.sender_id  = t.sid;
        bus.rx_data    = {120'h0, t.seq};
        bus.rx_len     = t.len;
        bus.rx_valid   = t.v;
        bus.rx_crc_err = t.e;
        for (int n = 0; n < 600 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin
                bus.rx_valid   = 1'b0;
                bus.rx_crc_err = 1'b0;
            end
            if (bus.tx_start) begin
                lat = n; f = bus.tx_data; l = bus.tx_len; d = bus.tx_dest_id;
            end
        end
        chk($sformatf("r%0d responded", idx), 128'(lat >= 0), 128'(t.resp));
        if (t.resp) begin
            chk($sformatf("r%0d latency", idx), 128'(lat), 128'd502);
            chk($sformatf("r%0d tx_data", idx), f, {110'h0, t.exp_f});
            chk($sformatf("r%0d tx_len", idx), 128'(l), 128'd3);
            chk($sformatf("r%0d tx_dest_id", idx), 128'(d), 128'(t.exp_dest));
            for (int k = 0; k < 50 && resp_busy; k++) begin
                @(posedge clk); #1;
            end
        end
        en = 1'b1;
        chk($sformatf("r%0d resp_busy", idx), 128'(resp_busy), 128'd0);
        chk($sformatf("r%0d dup_flag", idx), 128'(dup_flag), 128'(t.exp_dup));
        chk($sformatf("r%0d ack_cnt", idx), 128'(ack_cnt), 128'(t.exp_ack));
        chk($sformatf("r%0d nak_cnt", idx), 128'(nak_cnt), 128'(t.exp_nak));
    endtask

    initial begin
        int          n0, m;
        logic        seen;
        logic [19:0] e;
        n_chk = 0; n_pass = 0; n_start = 0; n_start2 = 0;
        //            v     e     en    sid   seq    len   resp  exp_f                    dest  dup   ack    nak
        tv[0] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h3C, 4'd4, 1'b1, {2'b01, 8'h3C, 8'hA5}, 2'd2, 1'b0, 8'd1, 8'd0};
        tv[1] = '{1'b0, 1'b1, 1'b1, 2'd3, 8'h77, 4'd4, 1'b1, {2'b01, 8'h00, 8'h5A}, 2'd3, 1'b0, 8'd1, 8'd1};
        tv[2] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h44, 4'd4, 1'b0, 18'h0,                 2'd0, 1'b0, 8'd1, 8'd1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h45, 4'd0, 1'b0, 18'h0,                 2'd0, 1'b0, 8'd1, 8'd1};
        tv[4] = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h55, 4'd4, 1'b1, {2'b01, 8'h00, 8'h5A}, 2'd0, 1'b0, 8'd1, 8'd2};
        tv[5] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h10, 4'd4, 1'b1, {2'b01, 8'h10, 8'hA5}, 2'd2, 1'b0, 8'd2, 8'd2};
        tv[6] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h10, 4'd4, 1'b1, {2'b01, 8'h10, 8'hA5}, 2'd2, 1'b1, 8'd3, 8'd2};
        tv[7] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h11, 4'd4, 1'b1, {2'b01, 8'h11, 8'hA5}, 2'd2, 1'b0, 8'd4, 8'd2};
        tv[8] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h10, 4'd4, 1'b1, {2'b01, 8'h10, 8'hA5}, 2'd0, 1'b0, 8'd5, 8'd2};
        tv[9] = '{1'b1, 1'b0, 1'b0, 2'd3, 8'h66, 4'd4, 1'b0, 18'h0,                 2'd0, 1'b0, 8'd5, 8'd2};

        rst_n = 1'b0; en = 1'b1; auto_busy = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_crc_err = 1'b0; bus.rx_data = '0; bus.rx_len = '0; bus.sender_id = '0;
        bus2.rx_valid = 1'b0; bus2.rx_crc_err = 1'b0; bus2.rx_data = '0; bus2.rx_len = '0;
        bus2.sender_id = '0; bus2.tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ack_cnt", 128'(ack_cnt), 128'd0);
        chk("reset nak_cnt", 128'(nak_cnt), 128'd0);
        chk("reset drop_cnt", 128'(drop_cnt), 128'd0);
        chk("reset timeout_err", 128'(tx_timeout_err), 128'd0);
        chk("reset resp_busy", 128'(resp_busy), 128'd0);
        chk("reset dup_flag", 128'(dup_flag), 128'd0);
        chk("reset tx_start", 128'(bus.tx_start), 128'd0);
        chk("reset tx_data", bus.tx_data, 128'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) run_row(i, tv[i]);

        // Three events 5 cycles apart: second is overwritten by the third while the first is in GAP.
        n0 = n_start;
        pulse(2'd2, 8'h21);
        repeat (3) @(negedge clk);
        pulse(2'd3, 8'h22);
        repeat (3) @(negedge clk);
        pulse(2'd0, 8'h23);
        repeat (2) @(negedge clk);
        chk("overwrite drop_cnt", 128'(drop_cnt), 128'd1);
        for (int k = 0; k < 2000 && n_start < n0 + 2; k++) @(negedge clk);
        repeat (600) @(negedge clk);
        chk("overwrite responses", 128'(n_start - n0), 128'd2);
        if (txq.size() >= 2) begin
            e = txq[txq.size() - 2];
            chk("overwrite first frame", 128'(e), 128'({2'd2, 2'b01, 8'h21, 8'hA5}));
            e = txq[txq.size() - 1];
            chk("overwrite last frame", 128'(e), 128'({2'd0, 2'b01, 8'h23, 8'hA5}));
        end else begin
            chk("overwrite frames captured", 128'(txq.size()), 128'd2);
        end
        chk("overwrite ack_cnt", 128'(ack_cnt), 128'd7);

        // Transmitter never goes busy: CONFIRM must time out after 1000 cycles.
        auto_busy = 1'b0;
        pulse(2'd2, 8'h30);
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.tx_start;
        end
        chk("timeout tx_start seen", 128'(seen), 128'd1);
        m = 0;
        while (m < 1200 && !tx_timeout_err) begin
            @(posedge clk); #1;
            m++;
        end
        chk("timeout cycles", 128'(m), 128'd1001);
        chk("timeout err", 128'(tx_timeout_err), 128'd1);
        chk("timeout ack_cnt", 128'(ack_cnt), 128'd7);
        chk("timeout resp_busy", 128'(resp_busy), 128'd0);
        chk("timeout tx_data", bus.tx_data, 128'd0);
        auto_busy = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-GAP with rx_valid held high across release.
        pulse(2'd3, 8'h40);
        repeat (100) @(negedge clk);
        bus.sender_id = 2'd2;
        bus.rx_valid  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset ack_cnt", 128'(ack_cnt), 128'd0);
        chk("midreset drop_cnt", 128'(drop_cnt), 128'd0);
        chk("midreset timeout_err", 128'(tx_timeout_err), 128'd0);
        chk("midreset resp_busy", 128'(resp_busy), 128'd0);
        chk("midreset tx_data", bus.tx_data, 128'd0);
        chk("midreset tx_dest_id", 128'(bus.tx_dest_id), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_start;
        repeat (700) @(negedge clk);
        chk("postreset no tx_start", 128'(n_start - n0), 128'd0);
        chk("postreset resp_busy", 128'(resp_busy), 128'd0);
        bus.rx_valid = 1'b0;

        // NAK_ENABLE = 0: CRC frame counted but not answered.
        @(negedge clk);
        bus2.sender_id  = 2'd3;
        bus2.rx_len     = 4'd4;
        bus2.rx_crc_err = 1'b1;
        @(negedge clk);
        bus2.rx_crc_err = 1'b0;
        repeat (600) @(negedge clk);
        chk("nakdis no tx_start", 128'(n_start2), 128'd0);
        chk("nakdis nak_cnt", 128'(nak_cnt2), 128'd1);
        chk("nakdis resp_busy", 128'(resp_busy2), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
